// File: rtl/neu_pkg.sv
// Shared types and constants for the node-array sequencer.
package neu_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RESET = 3'd2,
        ST_CLEAR = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Weight value marking a node that cannot be traversed
    localparam logic [3:0] WEIGHT_INACCESSIBLE = 4'hF;

    // Cost increments for orthogonal and diagonal moves
    localparam logic [1:0] PERP = 2'b10;
    localparam logic [1:0] DIAG = 2'b11;

    // Back-pointer direction as stored in each node
    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_e;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } dir_t;

    localparam int COST_SIZE = 12;
    localparam int RUN_CNT_W = 12;

endpackage

// File: rtl/neu_if.sv
// Host/array-facing signal bundle of the sequencer.
interface neu_if
    import neu_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 8
);
    localparam int N  = W * H;
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;

    logic                 start;
    logic [XW-1:0]        src_x;
    logic [YW-1:0]        src_y;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [3:0]           ld_data;
    logic [N-1:0]         mod_vec;
    logic                 arr_rst;
    logic [N-1:0]         arr_clr;
    logic [N-1:0]         arr_ld;
    logic [3:0]           arr_ld_weight;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic                 err;
    logic [RUN_CNT_W-1:0] run_cycles;

    // Host / array side
    modport master (
        output start, src_x, src_y, ld_valid, ld_data, mod_vec,
        input  ld_ready, arr_rst, arr_clr, arr_ld, arr_ld_weight,
               busy, done, timeout, err, run_cycles
    );

    // Sequencer side
    modport slave (
        input  start, src_x, src_y, ld_valid, ld_data, mod_vec,
        output ld_ready, arr_rst, arr_clr, arr_ld, arr_ld_weight,
               busy, done, timeout, err, run_cycles
    );

endinterface

// File: rtl/neu_conv_det.sv
// Convergence detector: registered OR of the array change flags and a
// counter of consecutive change-free RUN cycles.
module neu_conv_det
    import neu_pkg::*;
#(
    parameter int N            = 64,
    parameter int QUIET_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] mod_vec_i,
    output logic         converged_o
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_C = QW'(QUIET_CYCLES);

    logic          any_mod_q, any_mod_d;
    logic [QW-1:0] quiet_q, quiet_d;

    // Next-state of the change flag and quiet counter
    always_comb begin
        any_mod_d = |mod_vec_i;
        quiet_d   = quiet_q;
        if (clr_i) begin
            any_mod_d = 1'b0;
            quiet_d   = '0;
        end else if (en_i) begin
            if (any_mod_q) begin
                quiet_d = '0;
            end else if (quiet_q != QUIET_C) begin
                quiet_d = quiet_q + 1'b1;
            end
        end
    end

    // Converged in the cycle the counter reaches the quiet window length
    assign converged_o = en_i && !clr_i && (quiet_d == QUIET_C);

    // Detector state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            any_mod_q <= 1'b0;
            quiet_q   <= '0;
        end else begin
            any_mod_q <= any_mod_d;
            quiet_q   <= quiet_d;
        end
    end

endmodule

// File: rtl/neu_ctrl.sv
// Sequencer for a W x H relaxation array: weight load, array reset,
// source seed, relaxation run with convergence / timeout detection.
module neu_ctrl
    import neu_pkg::*;
#(
    parameter int W            = 8,
    parameter int H            = 8,
    parameter int QUIET_CYCLES = 8,
    parameter int MAX_RUN      = 4095
) (
    input  logic clk,
    input  logic rst,
    neu_if.slave bus
);
    localparam int N  = W * H;
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [XW:0]          W_C       = (XW + 1)'(W);
    localparam logic [YW:0]          H_C       = (YW + 1)'(H);
    localparam logic [IW-1:0]        LAST_IDX  = IW'(N - 1);
    localparam logic [RUN_CNT_W-1:0] MAX_RUN_C = RUN_CNT_W'(MAX_RUN);

    function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [XW-1:0]        sx_q, sx_d;
    logic [YW-1:0]        sy_q, sy_d;
    logic                 pend_q, pend_d;
    logic                 timeout_q, timeout_d;
    logic                 err_q, err_d;
    logic [RUN_CNT_W-1:0] run_q, run_d, run_inc;

    logic                 det_clr, det_en, converged;
    logic                 ld_ready, arr_rst;
    logic [N-1:0]         arr_ld, arr_clr;
    logic [3:0]           ld_w;
    logic [31:0]          clr_idx;

    neu_conv_det #(
        .N            (N),
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_conv_det (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (det_clr),
        .en_i        (det_en),
        .mod_vec_i   (bus.mod_vec),
        .converged_o (converged)
    );

    // State and job-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            pend_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            pend_q    <= pend_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            run_q     <= run_d;
        end
    end

    // Next-state logic and array strobes
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        pend_d    = pend_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        run_d     = run_q;
        det_clr   = 1'b0;
        det_en    = 1'b0;
        ld_ready  = 1'b0;
        arr_ld    = '0;
        ld_w      = '0;
        arr_clr   = '0;
        arr_rst   = rst;
        run_inc   = sat_inc(run_q);
        clr_idx   = 32'(sy_q) * 32'(W) + 32'(sx_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (pend_q) begin
                    // Bad source: one done-low cycle, then report the error
                    pend_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.start) begin
                    sx_d      = bus.src_x;
                    sy_d      = bus.src_y;
                    timeout_d = 1'b0;
                    err_d     = 1'b0;
                    run_d     = '0;
                    if ({1'b0, bus.src_x} >= W_C || {1'b0, bus.src_y} >= H_C) begin
                        pend_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    arr_ld = N'(1) << idx_q;
                    ld_w   = bus.ld_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RESET;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RESET: begin
                // After load so every node's sweep phase restarts together
                arr_rst = 1'b1;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                arr_clr = N'(1) << clr_idx;
                det_clr = 1'b1;
                run_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                det_en = 1'b1;
                run_d  = run_inc;
                if (converged) begin
                    state_d = ST_DONE;
                end else if (run_inc == MAX_RUN_C) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ld_ready      = ld_ready;
    assign bus.arr_rst       = arr_rst;
    assign bus.arr_clr       = arr_clr;
    assign bus.arr_ld        = arr_ld;
    assign bus.arr_ld_weight = ld_w;
    assign bus.busy          = !(state_q == ST_IDLE || state_q == ST_DONE);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.timeout       = timeout_q;
    assign bus.err           = err_q;
    assign bus.run_cycles    = run_q;

endmodule
